// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic {BLANK, SHOW} state_t;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  localparam logic [3:0] AN_DARK = 4'b1111;

  localparam digit_idx_t SEL_MIN_UNITS = 2'd2;
  localparam digit_idx_t SEL_MIN_TENS  = 2'd3;

  // Active-low one-hot anode for the selected digit.
  function automatic logic [3:0] an_select(input digit_idx_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; values 10..15 show a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with blanking gaps.
// Optional LEADING_ZERO_BLANK_EN keeps the minutes-tens digit dark when it is zero.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] digit,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  digit_idx_t       r_sel, w_sel_nxt;
  logic [3:0]       r_an, w_an_nxt;
  logic [6:0]       r_seg, w_seg_nxt;
  logic             r_dp, w_dp_nxt;
  logic             r_frame_tick, w_frame_tick_nxt;
  logic [6:0]       w_seg_dec;
  logic             w_blank_done;
  logic             w_show_done;
  logic             w_lz_blank;

  seg7_decode u_seg7_decode (
    .i_digit (digit),
    .o_seg_c (w_seg_dec)
  );

  assign w_blank_done = (r_cnt == CNT_W'(BLANK_CYC - 1));
  assign w_show_done  = (r_cnt == CNT_W'(DWELL_CYC - 1));

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = (r_sel == SEL_MIN_TENS) && (digit == 4'd0);
`else
  assign w_lz_blank = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_an         <= AN_DARK;
      r_seg        <= SEG_DARK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end
  end

  // Next-state and registered-output logic; disable forces a dark BLANK restart.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_sel_nxt        = r_sel;
    w_an_nxt         = r_an;
    w_seg_nxt        = r_seg;
    w_dp_nxt         = r_dp;
    w_frame_tick_nxt = 1'b0;

    if (!en) begin
      w_state_nxt = BLANK;
      w_cnt_nxt   = '0;
      w_an_nxt    = AN_DARK;
      w_seg_nxt   = SEG_DARK;
      w_dp_nxt    = 1'b1;
    end else begin
      case (r_state)
        BLANK: begin
          if (w_blank_done) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            w_seg_nxt   = w_seg_dec;
            w_an_nxt    = w_lz_blank ? AN_DARK : an_select(r_sel);
            w_dp_nxt    = (r_sel == SEL_MIN_UNITS) ? 1'b0 : 1'b1;
          end
        end
        SHOW: begin
          if (w_show_done) begin
            w_state_nxt      = BLANK;
            w_cnt_nxt        = '0;
            w_an_nxt         = AN_DARK;
            w_seg_nxt        = SEG_DARK;
            w_dp_nxt         = 1'b1;
            w_sel_nxt        = r_sel + 2'd1;
            w_frame_tick_nxt = (r_sel == SEL_MIN_TENS);
          end
        end
        default: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 and a
// modelled counter mux holding digits 1,2,3,4.
module tb_display_scan_ctrl;

  localparam logic [6:0] P_SEG_0    = 7'b1000000;
  localparam logic [6:0] P_SEG_1    = 7'b1111001;
  localparam logic [6:0] P_SEG_2    = 7'b0100100;
  localparam logic [6:0] P_SEG_3    = 7'b0110000;
  localparam logic [6:0] P_SEG_4    = 7'b0011001;
  localparam logic [6:0] P_SEG_DASH = 7'b0111111;
  localparam logic [6:0] P_SEG_DARK = 7'b1111111;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [3:0] digit;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  logic [3:0] digs [4];
  int         checks;
  int         errors;

  display_scan_ctrl #(
    .DWELL_CYC (4),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .digit      (digit),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb digit = digs[sel];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    digs[0] = 4'd1;
    digs[1] = 4'd2;
    digs[2] = 4'd3;
    digs[3] = 4'd4;
    reset_n = 1'b1;
    en      = 1'b1;
    #3 reset_n = 1'b0;
    cyc(3);
    chk("rst_an",  32'(an),  32'hF);
    chk("rst_seg", 32'(seg), 32'(P_SEG_DARK));
    chk("rst_dp",  32'(dp),  32'h1);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_ft",  32'(frame_tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // First frame: 2 blank then 4 shown cycles per digit.
    cyc(1); chk("e1_an", 32'(an), 32'hF);
    cyc(1); chk("e2_an", 32'(an), 32'hE);
            chk("e2_seg", 32'(seg), 32'(P_SEG_1));
            chk("e2_dp", 32'(dp), 32'h1);
            chk("e2_sel", 32'(sel), 32'h0);
    cyc(3); chk("e5_an", 32'(an), 32'hE);
    cyc(1); chk("e6_an", 32'(an), 32'hF);
            chk("e6_sel", 32'(sel), 32'h1);
            chk("e6_ft", 32'(frame_tick), 32'h0);
    cyc(2); chk("e8_an", 32'(an), 32'hD);
            chk("e8_seg", 32'(seg), 32'(P_SEG_2));
    cyc(4); chk("e12_sel", 32'(sel), 32'h2);
            chk("e12_an", 32'(an), 32'hF);
    cyc(2); chk("e14_an", 32'(an), 32'hB);
            chk("e14_seg", 32'(seg), 32'(P_SEG_3));
            chk("e14_dp", 32'(dp), 32'h0);
    cyc(4); chk("e18_sel", 32'(sel), 32'h3);
            chk("e18_dp", 32'(dp), 32'h1);
            chk("e18_an", 32'(an), 32'hF);
            chk("e18_ft", 32'(frame_tick), 32'h0);
    cyc(2); chk("e20_an", 32'(an), 32'h7);
            chk("e20_seg", 32'(seg), 32'(P_SEG_4));
    cyc(3); chk("e23_ft", 32'(frame_tick), 32'h0);
    cyc(1); chk("e24_ft", 32'(frame_tick), 32'h1);
            chk("e24_sel", 32'(sel), 32'h0);
            chk("e24_an", 32'(an), 32'hF);
    cyc(1); chk("e25_ft", 32'(frame_tick), 32'h0);

    // Out-of-range digit on sel 1 shows a dash.
    digs[1] = 4'd12;
    cyc(1); chk("e26_an", 32'(an), 32'hE);
    cyc(4); chk("e30_sel", 32'(sel), 32'h1);
    cyc(2); chk("dash_an", 32'(an), 32'hD);
            chk("dash_seg", 32'(seg), 32'(P_SEG_DASH));
    cyc(1);

    // Drop enable mid-SHOW of sel 1, then resume with a full blank.
    @(negedge clk);
    en = 1'b0;
    cyc(1); chk("dis_an", 32'(an), 32'hF);
            chk("dis_seg", 32'(seg), 32'(P_SEG_DARK));
            chk("dis_sel", 32'(sel), 32'h1);
    cyc(2); chk("dis2_an", 32'(an), 32'hF);
            chk("dis2_sel", 32'(sel), 32'h1);
            chk("dis2_ft", 32'(frame_tick), 32'h0);
    digs[1] = 4'd2;
    @(negedge clk);
    en = 1'b1;
    cyc(1); chk("ren1_an", 32'(an), 32'hF);
    cyc(1); chk("ren2_an", 32'(an), 32'hD);
            chk("ren2_seg", 32'(seg), 32'(P_SEG_2));
    cyc(3); chk("ren5_an", 32'(an), 32'hD);
    cyc(1); chk("ren6_an", 32'(an), 32'hF);
            chk("ren6_sel", 32'(sel), 32'h2);

    // Zero on the minutes-tens digit.
    digs[3] = 4'd0;
    cyc(6); chk("z_sel", 32'(sel), 32'h3);
    cyc(2);
`ifdef LEADING_ZERO_BLANK_EN
    chk("z_an", 32'(an), 32'hF);
`else
    chk("z_an", 32'(an), 32'h7);
    chk("z_seg", 32'(seg), 32'(P_SEG_0));
`endif
    chk("z_dp", 32'(dp), 32'h1);
    cyc(1);

    // Asynchronous reset between edges while a digit is lit.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an",  32'(an),  32'hF);
    chk("arst_seg", 32'(seg), 32'(P_SEG_DARK));
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_dp",  32'(dp),  32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2); chk("post_an", 32'(an), 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
